// File: rtl/mod_barrett_pipe.sv
// Pipelined Barrett reducer r = a mod q with a run-time loadable modulus.
// mu = floor(2^(2*MOD_W)/q) comes from a bit-serial restoring divider run on each load.
module mod_barrett_pipe #(
   parameter int MOD_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [MOD_W-1:0]  cfg_q_i,
   output logic              cfg_err_o,
   output logic              busy_o,
   output logic              mod_ok_o,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_a_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [MOD_W-1:0]  out_r_o
);

   localparam int T_W   = MOD_W + 2;
   localparam int PX_W  = 2*MOD_W + ((DATA_W > T_W) ? DATA_W : T_W);
   localparam int CNT_W = $clog2(2*MOD_W + 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(2*MOD_W);

   localparam logic [1:0] NOMOD = 2'd0;
   localparam logic [1:0] CALC  = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   if (DATA_W > 2*MOD_W) begin : g_bad_width
      $error("mod_barrett_pipe: DATA_W must not exceed 2*MOD_W");
   end

   // t < 3q < 2^T_W, so two conditional subtractions finish the reduction
   function automatic logic [MOD_W-1:0] fold(input logic [T_W-1:0] t,
                                             input logic [MOD_W-1:0] q);
      logic [T_W-1:0] qe;
      logic [T_W-1:0] r;
      qe = {2'b00, q};
      r  = t;
      if (r >= qe) r = r - qe;
      if (r >= qe) r = r - qe;
      return r[MOD_W-1:0];
   endfunction

   logic [1:0]         state;
   logic               cfg_err;
   logic [MOD_W-1:0]   div_q;
   logic [MOD_W-1:0]   q_r;
   logic [2*MOD_W-1:0] mu_r;
   logic [MOD_W-1:0]   rem;
   logic [2*MOD_W-2:0] quot;
   logic [CNT_W-1:0]   cnt;
   logic [MOD_W:0]     rem_sh;
   logic               rem_ge;
   logic [MOD_W-1:0]   rem_sub;

   logic               vld_p0, vld_p1, vld_p2;
   logic               en, pipe_empty;
   logic [DATA_W-1:0]  a_p0;
   logic [T_W-1:0]     a_p1, qhat_p1, t_p2;
   logic [PX_W-1:0]    prod;
   logic               unused_bits;

   // numerator is 2^(2*MOD_W): its only set bit is the first one shifted in
   assign rem_sh  = {rem, (cnt == CNT_TOP)};
   assign rem_ge  = (rem_sh >= {1'b0, div_q});
   assign rem_sub = rem_sh[MOD_W-1:0] - div_q;

   assign en          = !out_valid_o || out_ready_i;
   assign pipe_empty  = !(vld_p0 || vld_p1 || vld_p2 || out_valid_o);
   assign cfg_ready_o = (state != CALC) && pipe_empty;
   assign in_ready_o  = (state == RUN) && en;
   assign busy_o      = (state == CALC);
   assign mod_ok_o    = (state == RUN);
   assign cfg_err_o   = cfg_err;

   assign prod        = PX_W'(a_p0) * PX_W'(mu_r);
   assign unused_bits = ^prod;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= NOMOD;
         cfg_err <= 1'b0;
         div_q   <= '0;
         q_r     <= '0;
         mu_r    <= '0;
         rem     <= '0;
         quot    <= '0;
         cnt     <= '0;
      end else if (cfg_valid_i && cfg_ready_o) begin
         if (cfg_q_i < MOD_W'(2)) begin
            state   <= NOMOD;
            cfg_err <= 1'b1;
         end else begin
            state   <= CALC;
            cfg_err <= 1'b0;
            div_q   <= cfg_q_i;
            rem     <= '0;
            quot    <= '0;
            cnt     <= CNT_TOP;
         end
      end else if (state == CALC) begin
         rem  <= rem_ge ? rem_sub : rem_sh[MOD_W-1:0];
         quot <= {quot[2*MOD_W-3:0], rem_ge};
         cnt  <= cnt - 1'b1;
         // datapath q switches together with mu so in-flight operands keep a consistent pair
         if (cnt == '0) begin
            mu_r  <= {quot, rem_ge};
            q_r   <= div_q;
            state <= RUN;
         end
      end
   end

   // stage 1 captures a, stage 2 holds qhat, stage 3 holds t, output holds r
   always_ff @(posedge clk_i) begin
      if (en) begin
         a_p0    <= in_a_i;
         a_p1    <= T_W'(a_p0);
         qhat_p1 <= prod[2*MOD_W +: T_W];
         t_p2    <= a_p1 - qhat_p1 * {2'b00, q_r};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         out_valid_o <= 1'b0;
         out_r_o     <= '0;
      end else if (en) begin
         vld_p0      <= in_valid_i && in_ready_o;
         vld_p1      <= vld_p0;
         vld_p2      <= vld_p1;
         out_valid_o <= vld_p2;
         out_r_o     <= fold(t_p2, q_r);
      end
   end

endmodule

// File: tb/tb_mod_barrett_pipe.sv
// Scoreboard bench for mod_barrett_pipe: expected a%q queued at acceptance, compared at output.
module tb_mod_barrett_pipe;

   localparam int MOD_W  = 16;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [MOD_W-1:0]  cfg_q;
   logic              cfg_err;
   logic              busy;
   logic              mod_ok;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic              out_valid;
   logic              out_ready;
   logic [MOD_W-1:0]  out_r;

   int checks   = 0;
   int failures = 0;

   logic [MOD_W-1:0]  sb[$];
   logic [DATA_W-1:0] cur_q = 1;
   logic              prev_stall = 1'b0;
   logic [MOD_W-1:0]  prev_r = '0;
   logic              bp_on = 1'b0;
   logic              ok;

   mod_barrett_pipe #(.MOD_W(MOD_W), .DATA_W(DATA_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_q_i     (cfg_q),
      .cfg_err_o   (cfg_err),
      .busy_o      (busy),
      .mod_ok_o    (mod_ok),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_r_o     (out_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // output monitor and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'(out_r), 64'(prev_r));
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("result", 64'(out_r), 64'(sb.pop_front()));
         end
         if (in_valid && in_ready) sb.push_back(MOD_W'(in_a % cur_q));
         prev_stall <= out_valid && !out_ready;
         prev_r     <= out_r;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic cfg_send(input logic [MOD_W-1:0] q);
      logic acc;
      acc = 1'b0;
      cfg_valid = 1'b1;
      cfg_q     = q;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = cfg_ready;
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      check("cfg_accept", 64'(acc), 64'd1);
      if (q >= 2) cur_q = DATA_W'(q);
   endtask

   task automatic wait_calc();
      int n;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         if (i == 0) check("calc_modok_low", 64'(mod_ok), 64'd0);
         n++;
      end
      check("busy_cycles", 64'(n), 64'(2*MOD_W + 1));
      check("mod_ok_set", 64'(mod_ok), 64'd1);
      check("cfg_err_clear", 64'(cfg_err), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] a);
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      check("in_accept", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         done = !out_valid && (sb.size() == 0);
      end
      check("drain", 64'(done), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_q = '0;
      in_valid = 1'b0; in_a = '0; out_ready = 1'b1;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mod_ok", 64'(mod_ok), 64'd0);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_r", 64'(out_r), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // q=3329: divider timing, then single-operand latency
      cfg_send(16'd3329);
      wait_calc();
      send(32'd59099);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("latency_early", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
      check("latency_valid", 64'(out_valid), 64'd1);
      check("latency_r", 64'(out_r), 64'd2506);
      drain();
      send(32'hFFFF_FFFF);
      send(32'd9987);
      in_valid = 1'b0;
      drain();

      // q=400 back-to-back stream
      cfg_send(16'd400);
      wait_calc();
      send(32'd59099); send(32'd0); send(32'd399); send(32'd400);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b2b_valid", 64'(out_valid), 64'd1);
      end
      drain();

      // illegal modulus, recovery, and cfg blocked by a busy pipeline
      cfg_send(16'd1);
      @(negedge clk);
      check("q1_err", 64'(cfg_err), 64'd1);
      check("q1_mod_ok", 64'(mod_ok), 64'd0);
      check("q1_in_ready", 64'(in_ready), 64'd0);
      check("q1_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      cfg_send(16'd7681);
      wait_calc();
      send(32'd123456);
      send(32'd7681);
      in_valid = 1'b0;
      cfg_valid = 1'b1;
      cfg_q     = 16'd12289;
      @(negedge clk);
      check("cfg_blocked", 64'(cfg_ready), 64'd0);
      @(posedge clk); #1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = cfg_ready;
         if (ok) begin
            check("cfg_after_drain_valid", 64'(out_valid), 64'd0);
            check("cfg_after_drain_sb", 64'(sb.size()), 64'd0);
         end
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      check("cfg_drain_wait", 64'(ok), 64'd1);
      cur_q = 32'd12289;
      wait_calc();

      // backpressure with pseudo-random out_ready
      bp_on = 1'b1;
      fork
         begin
            while (bp_on) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join_none
      for (int i = 0; i < 8; i++) send($urandom);
      in_valid = 1'b0;
      drain();
      bp_on = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;

      // reset in the middle of a divider run
      @(posedge clk); #1;
      cfg_send(16'd3329);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rcalc_busy", 64'(busy), 64'd0);
      check("rcalc_mod_ok", 64'(mod_ok), 64'd0);
      check("rcalc_in_ready", 64'(in_ready), 64'd0);
      check("rcalc_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rcalc_idle_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;

      // reset while results are stalled in the pipeline
      cfg_send(16'd3329);
      wait_calc();
      out_ready = 1'b0;
      send(32'd1000); send(32'd2000); send(32'd3000);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      sb.delete();
      rst_n = 1'b0;
      #1;
      check("rstream_out_valid", 64'(out_valid), 64'd0);
      check("rstream_out_r", 64'(out_r), 64'd0);
      check("rstream_mod_ok", 64'(mod_ok), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstream_idle_valid", 64'(out_valid), 64'd0);
         check("rstream_idle_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      cfg_send(16'd3329);
      wait_calc();
      send(32'd59099);
      in_valid = 1'b0;
      drain();

      check("sb_final", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mod_barrett_pipe.md
Name: mod_barrett_pipe

Overview:
Pipelined, parametrised Barrett modular reducer for the PQ accelerator datapath. It computes r = a mod q at one result per cycle. The modulus q is loaded at run time. On each load, the block computes the Barrett constant mu = floor(2^(2*MOD_W)/q) itself, using an iterative restoring divider. It replaces the combinational mod_barrett. It provides a valid/ready stream interface and backpressure support, and it sits between the NTT/polynomial multiplier and the coefficient memory.

Parameters:
MOD_W, 16, maximum modulus width k; q < 2^MOD_W.
DATA_W, 32, input operand width; must satisfy DATA_W <= 2*MOD_W; elaboration-time assertion otherwise.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
cfg_valid_i  in  1  modulus load request
cfg_ready_o  out  1  modulus load accepted when high with cfg_valid_i
cfg_q_i  in  MOD_W  new modulus
cfg_err_o  out  1  sticky: last load had q < 2; cleared by next accepted load
busy_o  out  1  mu computation in progress
mod_ok_o  out  1  valid modulus and mu loaded
in_valid_i  in  1  operand valid
in_ready_o  out  1  operand accepted when high with in_valid_i
in_a_i  in  DATA_W  operand a, unsigned
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
out_r_o  out  MOD_W  a mod q

Behaviour:
- Reset (async assert, sync release) clears the following:
  - FSM goes to NOMOD.
  - cfg_err_o, busy_o, mod_ok_o, out_valid_o and all pipeline valid bits go to 0.
  - out_r_o, q and mu registers go to 0.
- FSM states:
  - NOMOD: no modulus loaded.
  - CALC: divider running.
  - RUN: reducing.
- Config handshake:
  - cfg_ready_o = (state != CALC) && pipeline empty (all 3 stage valids 0).
  - A load is accepted on a clock edge where cfg_valid_i && cfg_ready_o.
  - If q < 2: go to NOMOD, set cfg_err_o=1, mod_ok_o=0.
  - Otherwise: latch q, clear cfg_err_o, drop mod_ok_o, go to CALC.
- CALC:
  - Restoring division of the (2*MOD_W+1)-bit numerator 2^(2*MOD_W) by q, one quotient bit per cycle.
  - Runs exactly 2*MOD_W+1 cycles with busy_o=1; then mu is registered, state goes to RUN, mod_ok_o=1, busy_o=0.
  - mu width is 2*MOD_W; for q >= 2, mu <= 2^(2*MOD_W-1), so there is no overflow.
- Pipeline enable: en = !out_valid_o || out_ready_i. Stage registers and valids advance only when en=1.
- in_ready_o = (state == RUN) && en.
- Datapath stages:
  - Stage 1: register a; p = a*mu, full width.
  - Stage 2: qhat = p >> (2*MOD_W); t = a - qhat*q. t is guaranteed < 3q; compute at MOD_W+2 bits.
  - Stage 3: r = t; if r >= q then r -= q; if r >= q then r -= q. Register out_r_o and out_valid_o.
- Latency is 3 cycles: an operand accepted at edge N gives a result visible after edge N+3 when there is no stall. Throughput is 1 per cycle.
- Under stall (out_valid_o=1, out_ready_i=0):
  - All stages hold.
  - out_r_o stays stable.
  - in_ready_o=0.
  - No result is dropped or duplicated.
- Simultaneous in_valid_i and cfg_valid_i: cfg is accepted only if the pipeline is empty. If cfg is accepted in the same cycle, state leaves RUN, so in_ready_o is 0 next cycle. The operand offered that cycle is accepted only if in_ready_o was 1, and it then uses the old q/mu.
- cfg_valid_i during CALC is ignored (cfg_ready_o=0). The divider is never restarted mid-computation.
- Reset mid-CALC or mid-stream aborts everything. No output is produced until a new modulus is loaded.
- Results are exact for all a in [0, 2^DATA_W-1] and q in [2, 2^MOD_W-1].

Test Plan:
- Load q=3329 -> busy_o high exactly 33 cycles, mu=1290167, mod_ok_o=1. Then a=59099 -> out_r_o=2506, 3 cycles after acceptance.
- Load q=400; stream a=59099, 0, 399, 400 back-to-back with out_ready_i=1 -> 299, 0, 399, 0 on consecutive cycles.
- q=3329, a=0xFFFFFFFF -> 1352. Also a=3329*3 -> 0 (exercises the final-correction boundary).
- Backpressure: q=12289, stream 8 random operands; toggle out_ready_i pseudo-randomly -> results in order, match a%q, out_r_o stable while stalled.
- Load q=1 -> cfg_err_o=1, mod_ok_o=0, in_ready_o=0. Then load q=7681 -> cfg_err_o clears after CALC, mod_ok_o=1. Also cfg_valid_i with the pipeline non-empty -> cfg_ready_o=0 until drained.
- Assert rst_ni low mid-CALC and mid-stream -> all outputs 0 immediately (asynchronous). Afterwards in_ready_o=0 until a reload completes.
